// File: rtl/cdm16_mem_bridge_if.sv
// cdm16 bridge bus bundle: CPU strobes, memory port and GPU snoop stream.
// slave = bridge side, master = CPU/memory/GPU environment side.
interface cdm16_mem_bridge_if #(
  parameter int ADDR_W = 15,
  parameter int LVL_W  = 4
);
  logic [15:0]       cpu_addr;
  logic              cpu_mem;
  logic              cpu_read;
  logic              cpu_word;
  logic [15:0]       cpu_data_out;
  logic [15:0]       cpu_data_in;
  logic              cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_out;
  logic [15:0]       mem_in;
  logic              mem_en;
  logic [1:0]        mem_write;
  logic [15:0]       vram_addr;
  logic [15:0]       vram_data;
  logic [1:0]        vram_be;
  logic              vram_valid;
  logic              vram_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  cpu_addr, cpu_mem, cpu_read,
    input  cpu_word, cpu_data_out,
    input  mem_in, vram_ready,
    output cpu_data_in, cpu_hold,
    output mem_addr, mem_out, mem_en,
    output mem_write,
    output vram_addr, vram_data, vram_be,
    output vram_valid, fifo_level
  );

  modport master (
    output cpu_addr, cpu_mem, cpu_read,
    output cpu_word, cpu_data_out,
    output mem_in, vram_ready,
    input  cpu_data_in, cpu_hold,
    input  mem_addr, mem_out, mem_en,
    input  mem_write,
    input  vram_addr, vram_data, vram_be,
    input  vram_valid, fifo_level
  );
endinterface

// File: rtl/cdm16_mem_bridge.sv
// cdm16 CPU-to-BRAM bridge: lane steering, read-latency stall,
// and a VRAM write snoop FIFO that back-pressures the CPU when full.
module cdm16_mem_bridge #(
  parameter int          ADDR_W         = 15,
  parameter int          MEM_LATENCY    = 1,
  parameter logic [15:0] VRAM_BASE      = 16'hC000,
  parameter int          VRAM_SIZE_LOG2 = 13,
  parameter int          FIFO_DEPTH     = 8,
  parameter bit          SNOOP_BYTES    = 1'b0
) (
  input logic               clock,
  input logic               reset_n,
  cdm16_mem_bridge_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int VH = 16 - VRAM_SIZE_LOG2;
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);
  localparam logic [VH-1:0] WIN_TAG =
    VRAM_BASE[15:VRAM_SIZE_LOG2];
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, RWAIT, RDONE
  } state_e;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic [15:0]   rdata_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [15:0]   fa_q [FIFO_DEPTH];
  logic [15:0]   fd_q [FIFO_DEPTH];
  logic [1:0]    fb_q [FIFO_DEPTH];

  logic        idle_req, rd, wr;
  logic        in_win, snoop, full;
  logic        stall, push, pop;
  logic [1:0]  be;
  logic [15:0] wdata, rsteer;

  // reset_n gates the request so nothing is issued while in reset
  assign idle_req = reset_n & bus.cpu_mem
                  & (state_q == IDLE);
  assign rd = idle_req & bus.cpu_read;
  assign wr = idle_req & ~bus.cpu_read;

  assign be = bus.cpu_word    ? 2'b11 :
              bus.cpu_addr[0] ? 2'b10 : 2'b01;
  assign wdata =
    bus.cpu_word    ? bus.cpu_data_out :
    bus.cpu_addr[0] ? {bus.cpu_data_out[7:0], 8'd0} :
                      {8'd0, bus.cpu_data_out[7:0]};
  assign rsteer =
    bus.cpu_word    ? bus.mem_in :
    bus.cpu_addr[0] ? {8'd0, bus.mem_in[15:8]} :
                      {8'd0, bus.mem_in[7:0]};

  assign in_win =
    bus.cpu_addr[15:VRAM_SIZE_LOG2] == WIN_TAG;
  assign snoop = in_win & (bus.cpu_word | SNOOP_BYTES);
  // full uses the registered level: a same-cycle pop cannot free a slot
  assign full  = level_q == FULL_LVL;
  assign stall = wr & snoop & full;
  assign push  = wr & snoop & ~full;
  assign pop   = bus.vram_valid & bus.vram_ready;

  assign bus.mem_addr  = bus.cpu_addr[ADDR_W:1];
  assign bus.mem_out   = wdata;
  assign bus.mem_en    = idle_req | (state_q == RWAIT);
  assign bus.mem_write = (wr & ~stall) ? be : 2'b00;
  assign bus.cpu_hold  = stall | (state_q == RWAIT)
                       | (rd & (MEM_LATENCY != 0));
  assign bus.cpu_data_in =
    (MEM_LATENCY == 0) ? (rd ? rsteer : 16'd0) : rdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd && MEM_LATENCY != 0) begin
            cnt_q   <= LAT_M1;
            state_q <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt_q == 2'd0) begin
            rdata_q <= rsteer;
            state_q <= RDONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RDONE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fa_q[wptr_q] <= {bus.cpu_addr[15:1], 1'b0};
      fd_q[wptr_q] <= wdata;
      fb_q[wptr_q] <= be;
    end
  end

  assign bus.vram_valid = level_q != '0;
  assign bus.fifo_level = level_q;
  assign bus.vram_addr  =
    bus.vram_valid ? fa_q[rptr_q] : 16'd0;
  assign bus.vram_data  =
    bus.vram_valid ? fd_q[rptr_q] : 16'd0;
  assign bus.vram_be    =
    bus.vram_valid ? fb_q[rptr_q] : 2'b00;
endmodule

// File: tb/tb_cdm16_mem_bridge.sv
// Bench for cdm16_mem_bridge: three parameter sets driven one at a
// time by a CPU driver, a BRAM model and a GPU consumer with a scoreboard.
module tb_cdm16_mem_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdm16_mem_bridge_if #(.ADDR_W(15), .LVL_W(4)) b0 ();
  cdm16_mem_bridge_if #(.ADDR_W(15), .LVL_W(4)) b1 ();
  cdm16_mem_bridge_if #(.ADDR_W(15), .LVL_W(3)) b2 ();

  cdm16_mem_bridge #(.MEM_LATENCY(2), .SNOOP_BYTES(1'b0))
    d0 (.clock(clk), .reset_n(rst_n), .bus(b0.slave));
  cdm16_mem_bridge #(.MEM_LATENCY(0), .SNOOP_BYTES(1'b1))
    d1 (.clock(clk), .reset_n(rst_n), .bus(b1.slave));
  cdm16_mem_bridge #(.MEM_LATENCY(3), .SNOOP_BYTES(1'b1),
                     .FIFO_DEPTH(4))
    d2 (.clock(clk), .reset_n(rst_n), .bus(b2.slave));

  int checks = 0;
  int fails  = 0;
  int sel    = 0;

  logic [15:0] c_addr = 16'd0;
  logic [15:0] c_dout = 16'd0;
  logic        c_mem  = 1'b0;
  logic        c_read = 1'b0;
  logic        c_word = 1'b0;
  logic        ready  = 1'b0;
  logic        ready_force = 1'b0;
  bit          gpu_rand = 1'b0;
  logic [15:0] m_in;

  assign b0.cpu_addr = c_addr;
  assign b0.cpu_read = c_read;
  assign b0.cpu_word = c_word;
  assign b0.cpu_data_out = c_dout;
  assign b0.cpu_mem = c_mem && (sel == 0);
  assign b0.mem_in = m_in;
  assign b0.vram_ready = ready && (sel == 0);
  assign b1.cpu_addr = c_addr;
  assign b1.cpu_read = c_read;
  assign b1.cpu_word = c_word;
  assign b1.cpu_data_out = c_dout;
  assign b1.cpu_mem = c_mem && (sel == 1);
  assign b1.mem_in = m_in;
  assign b1.vram_ready = ready && (sel == 1);
  assign b2.cpu_addr = c_addr;
  assign b2.cpu_read = c_read;
  assign b2.cpu_word = c_word;
  assign b2.cpu_data_out = c_dout;
  assign b2.cpu_mem = c_mem && (sel == 2);
  assign b2.mem_in = m_in;
  assign b2.vram_ready = ready && (sel == 2);

  logic        o_hold, o_men, o_vv;
  logic [15:0] o_din, o_mout, o_va, o_vd;
  logic [14:0] o_maddr;
  logic [1:0]  o_mw, o_vbe;
  int          o_lvl;

  always_comb begin
    if (sel == 0) begin
      o_hold = b0.cpu_hold;  o_din = b0.cpu_data_in;
      o_maddr = b0.mem_addr; o_mout = b0.mem_out;
      o_men = b0.mem_en;     o_mw = b0.mem_write;
      o_va = b0.vram_addr;   o_vd = b0.vram_data;
      o_vbe = b0.vram_be;    o_vv = b0.vram_valid;
      o_lvl = int'(b0.fifo_level);
    end else if (sel == 1) begin
      o_hold = b1.cpu_hold;  o_din = b1.cpu_data_in;
      o_maddr = b1.mem_addr; o_mout = b1.mem_out;
      o_men = b1.mem_en;     o_mw = b1.mem_write;
      o_va = b1.vram_addr;   o_vd = b1.vram_data;
      o_vbe = b1.vram_be;    o_vv = b1.vram_valid;
      o_lvl = int'(b1.fifo_level);
    end else begin
      o_hold = b2.cpu_hold;  o_din = b2.cpu_data_in;
      o_maddr = b2.mem_addr; o_mout = b2.mem_out;
      o_men = b2.mem_en;     o_mw = b2.mem_write;
      o_va = b2.vram_addr;   o_vd = b2.vram_data;
      o_vbe = b2.vram_be;    o_vv = b2.vram_valid;
      o_lvl = int'(b2.fifo_level);
    end
  end

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 3;
  endfunction

  function automatic bit snp_of(int s);
    return (s != 0);
  endfunction

  function automatic logic [15:0] h(int i);
    return 16'(i * 40503 + 23130);
  endfunction

  // BRAM model with a selectable read latency
  logic [15:0] mem  [32768];
  logic [15:0] refm [32768];
  logic [15:0] p1 = 16'd0, p2 = 16'd0, p3 = 16'd0;
  bit          inited = 1'b0;
  logic        pl_en = 1'b0;
  logic [14:0] pl_a = 15'd0;
  logic [15:0] pl_d = 16'd0;

  always @(posedge clk) begin
    p1 <= mem[o_maddr];
    p2 <= p1;
    p3 <= p2;
    if (!inited) begin
      for (int i = 0; i < 32768; i++) mem[i] <= h(i);
      inited <= 1'b1;
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else begin
      if (o_mw[0]) mem[o_maddr][7:0]  <= o_mout[7:0];
      if (o_mw[1]) mem[o_maddr][15:8] <= o_mout[15:8];
    end
  end

  always_comb begin
    case (lat_of(sel))
      0:       m_in = mem[o_maddr];
      1:       m_in = p1;
      2:       m_in = p2;
      default: m_in = p3;
    endcase
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } snp_t;
  snp_t expq[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // GPU consumer: every accepted head must match the oldest snooped write
  always @(negedge clk) begin
    #1;
    ready = gpu_rand ? 1'($urandom_range(0, 1)) : ready_force;
    #1;
    if (rst_n && o_vv && ready) begin
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL vram_pop unexpected actual=%h required=none",
                 o_va);
      end else begin
        chk("vram_head", {o_va, o_vd, o_vbe},
            {expq[0].a, expq[0].d, expq[0].be});
        void'(expq.pop_front());
      end
    end
  end

  task automatic model_write(input bit wd,
                             input logic [15:0] a,
                             input logic [15:0] d);
    logic [15:0] sd;
    logic [1:0]  be;
    if (wd) begin
      sd = d; be = 2'b11;
    end else if (a[0]) begin
      sd = {d[7:0], 8'h00}; be = 2'b10;
    end else begin
      sd = {8'h00, d[7:0]}; be = 2'b01;
    end
    if (be[0]) refm[a >> 1][7:0]  = sd[7:0];
    if (be[1]) refm[a >> 1][15:8] = sd[15:8];
    if (a >= 16'hC000 && a < 16'hE000 && (wd || snp_of(sel)))
      expq.push_back('{a & 16'hFFFE, sd, be});
  endtask

  task automatic preload(input logic [15:0] a,
                         input logic [15:0] d);
    @(negedge clk);
    pl_a = a[15:1];
    pl_d = d;
    pl_en = 1'b1;
    refm[a >> 1] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic cpu_op(input bit rd, input bit wd,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        output logic [15:0] rdata,
                        output int nh,
                        output logic [1:0] mw,
                        output logic [15:0] mo,
                        output logic [14:0] ma);
    int k;
    @(negedge clk);
    c_addr = a; c_read = rd; c_word = wd;
    c_dout = d; c_mem = 1'b1;
    nh = 0; k = 0;
    #3;
    while (o_hold && k < 100) begin
      nh++; k++;
      @(negedge clk);
      #3;
    end
    if (k >= 100) begin
      checks++;
      fails++;
      $display("FAIL cpu_timeout actual=hold required=release");
    end
    rdata = o_din; mw = o_mw; mo = o_mout; ma = o_maddr;
    @(posedge clk);
    if (!rd && k < 100) model_write(wd, a, d);
    #1 c_mem = 1'b0;
  endtask

  task automatic drain();
    int k;
    gpu_rand = 1'b0;
    ready_force = 1'b1;
    k = 0;
    while (o_lvl != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #3;
    chk("drain_level", 64'(o_lvl), 64'd0);
    chk("drain_queue", 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  typedef struct {
    int          sel;
    bit          rd;
    bit          wd;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] mv;
    logic [15:0] er;
    logic [1:0]  emw;
    logic [15:0] emo;
  } vec_t;
  vec_t tbl[14];

  initial begin
    logic [15:0] rdata, mo, a, d, er;
    logic [14:0] ma;
    logic [1:0]  mw;
    logic [31:0] r;
    int          nh, enh, bad;
    bit          rd, wd;

    tbl[0]  = '{0, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'hBEEF,
                16'hBEEF, 2'b00, 16'h0000};
    tbl[1]  = '{0, 1'b1, 1'b1, 16'h0301, 16'h0000, 16'h5A5A,
                16'h5A5A, 2'b00, 16'h0000};
    tbl[2]  = '{0, 1'b1, 1'b0, 16'h0401, 16'h0000, 16'h77EE,
                16'h0077, 2'b00, 16'h0000};
    tbl[3]  = '{0, 1'b0, 1'b1, 16'hC010, 16'h1234, 16'h0000,
                16'h0000, 2'b11, 16'h1234};
    tbl[4]  = '{0, 1'b0, 1'b0, 16'hC011, 16'h0056, 16'h0000,
                16'h0000, 2'b10, 16'h5600};
    tbl[5]  = '{0, 1'b0, 1'b0, 16'h1000, 16'hFFAA, 16'h0000,
                16'h0000, 2'b01, 16'h00AA};
    tbl[6]  = '{0, 1'b0, 1'b1, 16'hDFFE, 16'hCAFE, 16'h0000,
                16'h0000, 2'b11, 16'hCAFE};
    tbl[7]  = '{0, 1'b0, 1'b1, 16'hE000, 16'h0BAD, 16'h0000,
                16'h0000, 2'b11, 16'h0BAD};
    tbl[8]  = '{0, 1'b0, 1'b1, 16'hBFFE, 16'hFEED, 16'h0000,
                16'h0000, 2'b11, 16'hFEED};
    tbl[9]  = '{1, 1'b1, 1'b0, 16'h0101, 16'h0000, 16'hAB12,
                16'h00AB, 2'b00, 16'h0000};
    tbl[10] = '{1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hAB12,
                16'h0012, 2'b00, 16'h0000};
    tbl[11] = '{1, 1'b0, 1'b0, 16'hC011, 16'h3356, 16'h0000,
                16'h0000, 2'b10, 16'h5600};
    tbl[12] = '{1, 1'b0, 1'b1, 16'h0003, 16'hA5C3, 16'h0000,
                16'h0000, 2'b11, 16'hA5C3};
    tbl[13] = '{2, 1'b1, 1'b0, 16'h0500, 16'h0000, 16'h1234,
                16'h0034, 2'b00, 16'h0000};

    for (int i = 0; i < 32768; i++) refm[i] = h(i);

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_outputs",
          {o_hold, o_din, o_men, o_mw, o_vv, o_va, o_vd, o_vbe},
          64'd0);
      chk("reset_level", 64'(o_lvl), 64'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_force = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].sel != sel) begin
        drain();
        sel = tbl[i].sel;
      end
      if (tbl[i].rd) preload(tbl[i].a, tbl[i].mv);
      cpu_op(tbl[i].rd, tbl[i].wd, tbl[i].a, tbl[i].d,
             rdata, nh, mw, mo, ma);
      enh = (tbl[i].rd && lat_of(sel) > 0) ? lat_of(sel) + 1 : 0;
      chk("tbl_hold_cycles", 64'(nh), 64'(enh));
      chk("tbl_mem_write", 64'(mw), 64'(tbl[i].emw));
      chk("tbl_mem_out", 64'(mo), 64'(tbl[i].emo));
      chk("tbl_mem_addr", 64'(ma), 64'(tbl[i].a >> 1));
      if (tbl[i].rd) chk("tbl_rdata", 64'(rdata), 64'(tbl[i].er));
    end
    drain();

    // snooped write appears at the FIFO head on the next cycle
    sel = 0;
    ready_force = 1'b0;
    cpu_op(1'b0, 1'b1, 16'hC010, 16'h1234, rdata, nh, mw, mo, ma);
    @(negedge clk);
    #3;
    chk("head_after_push", {o_vv, o_va, o_vd, o_vbe},
        {1'b1, 16'hC010, 16'h1234, 2'b11});
    chk("level_one", 64'(o_lvl), 64'd1);

    // fill to 8, then a ninth snooped write must stall
    for (int i = 0; i < 7; i++)
      cpu_op(1'b0, 1'b1, 16'hC020 + 16'(2 * i), 16'(i),
             rdata, nh, mw, mo, ma);
    @(negedge clk);
    #3;
    chk("level_full", 64'(o_lvl), 64'd8);
    @(negedge clk);
    c_addr = 16'hC100; c_read = 1'b0; c_word = 1'b1;
    c_dout = 16'h9999; c_mem = 1'b1;
    #3;
    chk("full_hold", 64'(o_hold), 64'd1);
    chk("full_no_write", 64'(o_mw), 64'd0);
    @(negedge clk);
    #3;
    chk("full_hold_2", {o_hold, o_mw}, 64'b100);
    @(negedge clk);
    ready_force = 1'b1;
    #3;
    chk("pop_cycle_still_held", {o_hold, o_mw}, 64'b100);
    @(negedge clk);
    ready_force = 1'b0;
    #3;
    chk("after_pop_release", {o_hold, o_mw}, 64'b011);
    chk("after_pop_level", 64'(o_lvl), 64'd7);
    @(posedge clk);
    model_write(1'b1, 16'hC100, 16'h9999);
    #1 c_mem = 1'b0;
    @(negedge clk);
    #3;
    chk("refill_level", 64'(o_lvl), 64'd8);
    drain();

    // asynchronous reset in the middle of a read with 3 entries queued
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++)
      cpu_op(1'b0, 1'b1, 16'hC200 + 16'(2 * i), 16'h0F00,
             rdata, nh, mw, mo, ma);
    @(negedge clk);
    #3;
    chk("pre_reset_level", 64'(o_lvl), 64'd3);
    @(negedge clk);
    c_addr = 16'h0200; c_read = 1'b1; c_word = 1'b1; c_mem = 1'b1;
    @(negedge clk);
    #3;
    chk("rwait_hold", 64'(o_hold), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_abort", {o_hold, o_vv, o_mw, o_men}, 64'd0);
    chk("reset_flush", 64'(o_lvl), 64'd0);
    expq.delete();
    c_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    chk("post_reset_idle", {o_hold, o_vv, o_din}, 64'd0);

    // randomized traffic against the reference memory and snoop queue
    for (int s = 0; s < 3; s++) begin
      drain();
      sel = s;
      gpu_rand = 1'b1;
      for (int n = 0; n < 120; n++) begin
        r = $urandom;
        a = r[31:16];
        if (r[1:0] < 2)
          a = 16'hC000 | (a & 16'h003F);
        else if (r[1:0] == 2)
          a = a & 16'h00FF;
        else
          a = (r[2] ? 16'hBFF0 : 16'hDFF0) | (a & 16'h001F);
        rd = r[3];
        wd = r[4];
        d = 16'($urandom);
        if (wd) er = refm[a >> 1];
        else if (a[0]) er = {8'h00, refm[a >> 1][15:8]};
        else er = {8'h00, refm[a >> 1][7:0]};
        cpu_op(rd, wd, a, d, rdata, nh, mw, mo, ma);
        if (rd) begin
          enh = (lat_of(sel) > 0) ? lat_of(sel) + 1 : 0;
          chk("rand_rdata", 64'(rdata), 64'(er));
          chk("rand_hold", 64'(nh), 64'(enh));
        end
      end
    end
    drain();

    bad = 0;
    for (int i = 0; i < 32768; i++)
      if (mem[i] !== refm[i]) bad++;
    chk("memory_image", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
